// File: rtl/i2c_pkg.sv
// Shared definitions for the oversampled I2C register slave.
// Holds the FSM state encoding, the SDA levels that mean ACK/NACK,
// the general-call address and the index wrap helper.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_IDX  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;
    localparam logic [2:0] ST_WAIT = 3'd5;

    // SDA line levels during an acknowledge slot
    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;

    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

    // Register index increment that wraps from n-1 back to 0
    function automatic logic [7:0] wrap_inc(input logic [7:0] idx, input logic [8:0] n);
        logic [8:0] nxt;
        nxt = {1'b0, idx} + 9'd1;
        if (nxt >= n) begin
            wrap_inc = 8'd0;
        end else begin
            wrap_inc = nxt[7:0];
        end
    endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Synchroniser + glitch filter + edge detector for one I2C pad input.
// Ports:
//   clk     system clock
//   RST     synchronous active-high reset (filtered level resets to 1)
//   d_i     raw asynchronous pad input
//   level_o filtered level
//   rise_o  one-clk pulse when level_o goes 0->1 (aligned with level_o)
//   fall_o  one-clk pulse when level_o goes 1->0 (aligned with level_o)
module i2c_in_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic RST,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   filt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, run-length filter and edge pulses
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the output;
            // the FILT_LEN-th such sample flips the output.
            if (sync_s != filt_q) begin
                if (cnt_q == CW'(FILT_LEN - 1)) begin
                    filt_q <= ~filt_q;
                    cnt_q  <= '0;
                    rise_q <= ~filt_q;
                    fall_q <= filt_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// Fully synchronous I2C slave serving NUM_REGS x 8-bit registers.
// Protocol: [START][DEV_ADDR+W][index][data...] writes with auto-increment;
// [START][DEV_ADDR+W][index][RESTART][DEV_ADDR+R][data...] reads.
// Optional build macro: I2C_SLAVE_GEN_CALL_EN (general call 8'h00 writes
// from register 0; without it 8'h00 is an ordinary address mismatch).
// Ports:
//   clk, RST   system clock, synchronous active-high reset
//   scl_i      raw SCL pad input
//   sda_i      raw SDA pad input (wired line)
//   sda_oe     1 = pull SDA low
//   regs_o     flat register file, reg k at [8k+7:8k]
//   wr_pulse   one-clk pulse per register write, wr_idx = written index
//   busy       transfer addressed to this slave in progress
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h55,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_pulse,
    output logic [7:0]            wr_idx,
    output logic                  busy
);

    import i2c_pkg::*;

`ifdef I2C_SLAVE_GEN_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    localparam logic [8:0] NREGS_W = 9'(NUM_REGS);

    logic scl_s, scl_rise_s, scl_fall_s;
    logic sda_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    logic [2:0]            state_q, state_d, pend_q, pend_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  got_bit_q, got_bit_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            index_q, index_d;
    logic                  mack_q, mack_d;
    logic                  addr_ack_q, addr_ack_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [7:0]            wr_idx_q, wr_idx_d;
    logic                  busy_q, busy_d;
    logic [7:0]            nxt_idx_s, rd_byte_s, rd_next_s;

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .RST(RST), .d_i(scl_i),
        .level_o(scl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );

    i2c_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .RST(RST), .d_i(sda_i),
        .level_o(sda_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_s;
    assign stop_s    = sda_rise_s & scl_s;
    assign nxt_idx_s = wrap_inc(index_q, NREGS_W);

    // Read muxes: current register and the one after it (for burst reload)
    always_comb begin
        rd_byte_s = 8'h00;
        rd_next_s = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            rd_byte_s = (index_q   == 8'(k)) ? regs_q[k*8 +: 8] : rd_byte_s;
            rd_next_s = (nxt_idx_s == 8'(k)) ? regs_q[k*8 +: 8] : rd_next_s;
        end
    end

    // Protocol FSM next-state logic
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        bit_cnt_d  = bit_cnt_q;
        got_bit_d  = got_bit_q;
        shift_d    = shift_q;
        index_d    = index_q;
        mack_d     = mack_q;
        addr_ack_d = addr_ack_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;

        if (stop_s) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            index_d    = 8'd0;
            bit_cnt_d  = 4'd0;
            got_bit_d  = 1'b0;
            addr_ack_d = 1'b0;
        end else if (start_s) begin
            // index is kept so a write of the index can be followed by a read
            state_d    = ST_ADDR;
            sda_oe_d   = 1'b0;
            bit_cnt_d  = 4'd0;
            got_bit_d  = 1'b0;
            addr_ack_d = 1'b0;
        end else if ((state_q == ST_IDLE) || (state_q == ST_WAIT)) begin
            sda_oe_d = 1'b0;
        end else if (scl_rise_s) begin
            got_bit_d = 1'b1;
            if (bit_cnt_q == 4'd8) begin
                mack_d = sda_s;
            end else if (state_q != ST_RD) begin
                shift_d = {shift_q[6:0], sda_s};
            end else begin
                shift_d = shift_q;
            end
        end else if (scl_fall_s && got_bit_q) begin
            // got_bit_q suppresses the SCL fall that directly follows START
            got_bit_d = 1'b0;
            if (bit_cnt_q == 4'd8) begin
                bit_cnt_d  = 4'd0;
                addr_ack_d = 1'b0;
                if (state_q == ST_RD) begin
                    if (mack_q == NACK_BIT) begin
                        state_d  = ST_WAIT;
                        sda_oe_d = 1'b0;
                    end else begin
                        index_d  = nxt_idx_s;
                        shift_d  = rd_next_s;
                        sda_oe_d = ~rd_next_s[7];
                    end
                end else begin
                    state_d = pend_q;
                    if (pend_q == ST_RD) begin
                        shift_d  = rd_byte_s;
                        sda_oe_d = ~rd_byte_s[7];
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    // byte complete: decide the acknowledge slot
                    case (state_q)
                        ST_ADDR: begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                sda_oe_d   = ~ACK_BIT;
                                addr_ack_d = 1'b1;
                                pend_d     = shift_q[0] ? ST_RD : ST_IDX;
                            end else if (GC_EN && (shift_q == {GEN_CALL_ADDR, 1'b0})) begin
                                sda_oe_d   = ~ACK_BIT;
                                addr_ack_d = 1'b1;
                                index_d    = 8'd0;
                                pend_d     = ST_WR;
                            end else begin
                                sda_oe_d = 1'b0;
                                pend_d   = ST_WAIT;
                            end
                        end
                        ST_IDX: begin
                            if ({1'b0, shift_q} < NREGS_W) begin
                                index_d  = shift_q;
                                sda_oe_d = ~ACK_BIT;
                                pend_d   = ST_WR;
                            end else begin
                                sda_oe_d = 1'b0;
                                pend_d   = ST_WAIT;
                            end
                        end
                        ST_WR: begin
                            wr_pulse_d = 1'b1;
                            wr_idx_d   = index_q;
                            index_d    = nxt_idx_s;
                            sda_oe_d   = ~ACK_BIT;
                            pend_d     = ST_WR;
                        end
                        ST_RD: begin
                            // let the master drive its ACK/NACK
                            sda_oe_d = 1'b0;
                        end
                        default: begin
                            sda_oe_d = 1'b0;
                        end
                    endcase
                end else if (state_q == ST_RD) begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    sda_oe_d = ~shift_q[6];
                end else begin
                    shift_d = shift_q;
                end
            end
        end else begin
            got_bit_d = got_bit_q;
        end

        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_pulse_d && (index_q == 8'(k))) begin
                regs_d[k*8 +: 8] = shift_q;
            end else begin
                regs_d[k*8 +: 8] = regs_q[k*8 +: 8];
            end
        end

        busy_d = (state_d == ST_IDX) || (state_d == ST_WR) || (state_d == ST_RD) ||
                 ((state_d == ST_ADDR) && addr_ack_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pend_q     <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            got_bit_q  <= 1'b0;
            shift_q    <= 8'h00;
            index_q    <= 8'd0;
            mack_q     <= NACK_BIT;
            addr_ack_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            regs_q     <= '0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= 8'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            bit_cnt_q  <= bit_cnt_d;
            got_bit_q  <= got_bit_d;
            shift_q    <= shift_d;
            index_q    <= index_d;
            mack_q     <= mack_d;
            addr_ack_q <= addr_ack_d;
            sda_oe_q   <= sda_oe_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign regs_o   = regs_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile (DEV_ADDR=0x55, NUM_REGS=4).
// A behavioural I2C master drives SCL/SDA with quarter-bit spacing of Q clks;
// the SDA line is the wired-AND of master and slave.
module tb_i2c_slave_regfile;

    localparam int Q = 10;

`ifdef I2C_SLAVE_GEN_CALL_EN
    localparam logic GC_ACK = 1'b1;
    localparam logic [7:0] GC_REG0 = 8'h77;
`else
    localparam logic GC_ACK = 1'b0;
    localparam logic [7:0] GC_REG0 = 8'h00;
`endif

    logic        clk   = 1'b0;
    logic        RST   = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [31:0] regs_o;
    logic        wr_pulse;
    logic [7:0]  wr_idx;
    logic        busy;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    logic [7:0]  last_idx = 8'h00;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(
        .DEV_ADDR(7'h55), .NUM_REGS(4), .SYNC_STAGES(2), .FILT_LEN(3)
    ) dut (
        .clk(clk), .RST(RST), .scl_i(scl_m), .sda_i(sda_line),
        .sda_oe(sda_oe), .regs_o(regs_o), .wr_pulse(wr_pulse),
        .wr_idx(wr_idx), .busy(busy)
    );

    // Write-strobe monitor
    always @(posedge clk) begin
        if (wr_pulse) begin
            wr_cnt   <= wr_cnt + 1;
            last_idx <= wr_idx;
        end
    end

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b1; wait_q(Q);
    endtask

    task automatic i2c_wbyte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q(Q);
            scl_m = 1'b1; wait_q(2 * Q);
            scl_m = 1'b0; wait_q(Q);
        end
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        acked = sda_oe;
        wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic i2c_rbyte(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_q(Q);
            scl_m = 1'b1; wait_q(Q);
            b[i] = sda_line;
            wait_q(Q);
            scl_m = 1'b0; wait_q(Q);
        end
        sda_m = nack; wait_q(Q);
        scl_m = 1'b1; wait_q(2 * Q);
        scl_m = 1'b0; wait_q(Q);
        sda_m = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        wait_q(5);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        n_tests++; if (regs_o !== 32'h0) begin n_fail++; $display("FAIL rst_regs got=%h exp=0", regs_o); end
        n_tests++; if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_wr_pulse got=%b exp=0", wr_pulse); end
        n_tests++; if (wr_idx !== 8'h00) begin n_fail++; $display("FAIL rst_wr_idx got=%h exp=0", wr_idx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        RST = 1'b0;
        wait_q(Q);
    endtask

    task automatic test_write;
        logic a; int c0;
        c0 = wr_cnt;
        i2c_start;
        i2c_wbyte(8'hAA, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack got=%b exp=1", a); end
        i2c_wbyte(8'h03, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL wr_idx_ack got=%b exp=1", a); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got=%b exp=1", busy); end
        i2c_wbyte(8'h57, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack got=%b exp=1", a); end
        i2c_stop;
        n_tests++; if (wr_cnt - c0 !== 1) begin n_fail++; $display("FAIL wr_pulse_cnt got=%0d exp=1", wr_cnt - c0); end
        n_tests++; if (last_idx !== 8'd3) begin n_fail++; $display("FAIL wr_idx_val got=%h exp=03", last_idx); end
        n_tests++; if (regs_o !== 32'h5700_0000) begin n_fail++; $display("FAIL wr_regs got=%h exp=57000000", regs_o); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_read_restart;
        logic a; logic [7:0] rb;
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h01, a); i2c_wbyte(8'h5A, a); i2c_stop;
        n_tests++; if (regs_o !== 32'h5700_5A00) begin n_fail++; $display("FAIL rd_setup_regs got=%h exp=57005a00", regs_o); end
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h01, a);
        i2c_start;
        i2c_wbyte(8'hAB, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy got=%b exp=1", busy); end
        i2c_rbyte(1'b1, rb);
        n_tests++; if (rb !== 8'h5A) begin n_fail++; $display("FAIL rd_data got=%h exp=5a", rb); end
        i2c_stop;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_burst;
        logic a; logic [7:0] rb; int c0;
        c0 = wr_cnt;
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h02, a);
        i2c_wbyte(8'h11, a); i2c_wbyte(8'h22, a); i2c_wbyte(8'h33, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL burst_wrap_ack got=%b exp=1", a); end
        i2c_stop;
        n_tests++; if (regs_o !== 32'h2211_5A33) begin n_fail++; $display("FAIL burst_regs got=%h exp=22115a33", regs_o); end
        n_tests++; if (wr_cnt - c0 !== 3) begin n_fail++; $display("FAIL burst_wr_cnt got=%0d exp=3", wr_cnt - c0); end
        n_tests++; if (last_idx !== 8'd0) begin n_fail++; $display("FAIL burst_last_idx got=%h exp=00", last_idx); end
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h02, a);
        i2c_start; i2c_wbyte(8'hAB, a);
        i2c_rbyte(1'b0, rb);
        n_tests++; if (rb !== 8'h11) begin n_fail++; $display("FAIL burst_rd0 got=%h exp=11", rb); end
        i2c_rbyte(1'b0, rb);
        n_tests++; if (rb !== 8'h22) begin n_fail++; $display("FAIL burst_rd1 got=%h exp=22", rb); end
        i2c_rbyte(1'b1, rb);
        n_tests++; if (rb !== 8'h33) begin n_fail++; $display("FAIL burst_rd2 got=%h exp=33", rb); end
        i2c_stop;
    endtask

    task automatic test_negative;
        logic a; int c0;
        c0 = wr_cnt;
        i2c_start;
        i2c_wbyte(8'hA8, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL neg_addr_ack got=%b exp=0", a); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL neg_addr_busy got=%b exp=0", busy); end
        i2c_wbyte(8'hAA, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL neg_wait_ack got=%b exp=0", a); end
        i2c_stop;
        i2c_start; i2c_wbyte(8'hAA, a);
        i2c_wbyte(8'h09, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL neg_idx_ack got=%b exp=0", a); end
        i2c_wbyte(8'h66, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL neg_data_ack got=%b exp=0", a); end
        i2c_stop;
        n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL neg_wr_cnt got=%0d exp=0", wr_cnt - c0); end
        n_tests++; if (regs_o !== 32'h2211_5A33) begin n_fail++; $display("FAIL neg_regs got=%h exp=22115a33", regs_o); end
    endtask

    task automatic test_glitch;
        logic a;
        i2c_start; i2c_wbyte(8'hAA, a);
        @(negedge clk); scl_m = 1'b1;
        @(negedge clk); scl_m = 1'b0;
        wait_q(Q);
        i2c_wbyte(8'h03, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL glitch_idx_ack got=%b exp=1", a); end
        i2c_wbyte(8'h44, a);
        i2c_stop;
        n_tests++; if (regs_o !== 32'h4411_5A33) begin n_fail++; $display("FAIL glitch_regs got=%h exp=44115a33", regs_o); end
    endtask

    task automatic test_abort;
        logic a; int c0;
        c0 = wr_cnt;
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h00, a);
        for (int i = 0; i < 4; i++) begin
            sda_m = i[0]; wait_q(Q);
            scl_m = 1'b1; wait_q(2 * Q);
            scl_m = 1'b0; wait_q(Q);
        end
        i2c_stop;
        n_tests++; if (wr_cnt - c0 !== 0) begin n_fail++; $display("FAIL abort_wr_cnt got=%0d exp=0", wr_cnt - c0); end
        n_tests++; if (regs_o !== 32'h4411_5A33) begin n_fail++; $display("FAIL abort_regs got=%h exp=44115a33", regs_o); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_rst_mid_read;
        logic a;
        i2c_start; i2c_wbyte(8'hAA, a); i2c_wbyte(8'h03, a);
        i2c_start; i2c_wbyte(8'hAB, a);
        // reg3 = 0x44, MSB 0 -> slave pulls SDA low for the first bit
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstrd_drive got=%b exp=1", sda_oe); end
        @(negedge clk); RST = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstrd_release got=%b exp=0", sda_oe); end
        scl_m = 1'b1; sda_m = 1'b1;
        wait_q(5);
        RST = 1'b0;
        wait_q(Q);
        n_tests++; if (regs_o !== 32'h0) begin n_fail++; $display("FAIL rstrd_regs got=%h exp=0", regs_o); end
    endtask

    task automatic test_gen_call;
        logic a;
        i2c_start;
        i2c_wbyte(8'h00, a);
        n_tests++; if (a !== GC_ACK) begin n_fail++; $display("FAIL gc_addr_ack got=%b exp=%b", a, GC_ACK); end
        i2c_wbyte(8'h77, a);
        n_tests++; if (a !== GC_ACK) begin n_fail++; $display("FAIL gc_data_ack got=%b exp=%b", a, GC_ACK); end
        i2c_stop;
        n_tests++; if (regs_o[7:0] !== GC_REG0) begin n_fail++; $display("FAIL gc_reg0 got=%h exp=%h", regs_o[7:0], GC_REG0); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_restart;
        test_burst;
        test_negative;
        test_glitch;
        test_abort;
        test_rst_mid_read;
        test_gen_call;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
